i2c_host_txn_sequencer: RTL and testbench

Transaction-level controller for the I2C host PHY integration. It accepts one request per transfer (7-bit target address, direction, length) and turns it into the PHY's format-FIFO entries (byte plus flags). It streams write data in and read data out, handles NAK and stretch-timeout aborts, and reports a completion status. It sits between the register/CSR front-end and the PHY, and owns the PHY's fmt_fifo_* and unhandled_unexp_nak_i inputs.

---
 rtl/i2c_host_txn_sequencer.sv | 162 ++++++++++++++++
 tb/tb_i2c_host_txn_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_host_txn_sequencer.sv
// i2c_host_txn_sequencer: turns one I2C transfer request into PHY format-FIFO entries and reports completion
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   req_*                                transfer request (addr, rnw, len) with valid/ready
//   wdata_*                              write byte stream in, consumed on valid & ready
//   rdata_valid_o, rdata_o               read byte strobe out, one cycle after the PHY rx strobe
//   done_o, status_o                     completion pulse with 0 OK, 1 addr NAK, 2 data NAK, 3 timeout
//   fmt_fifo_*, fmt_byte_o, fmt_flag_*   format entry presented to the PHY
//   unhandled_unexp_nak_o                held while flushing an aborted transfer
//   host_idle_i, event_*                 PHY status and abort events
//   rx_fifo_wvalid_i, rx_fifo_wdata_i    PHY received-byte strobe
module i2c_host_txn_sequencer #(
    parameter int FifoDepth = 64,
    localparam int FifoDepthWidth = $clog2(FifoDepth + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [6:0]                req_addr_i,
    input  logic                      req_rnw_i,
    input  logic [7:0]                req_len_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [7:0]                wdata_i,
    output logic                      rdata_valid_o,
    output logic [7:0]                rdata_o,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic                      fmt_fifo_rvalid_o,
    output logic [FifoDepthWidth-1:0] fmt_fifo_depth_o,
    input  logic                      fmt_fifo_rready_i,
    output logic [7:0]                fmt_byte_o,
    output logic                      fmt_flag_start_before_o,
    output logic                      fmt_flag_stop_after_o,
    output logic                      fmt_flag_read_bytes_o,
    output logic                      fmt_flag_read_continue_o,
    output logic                      fmt_flag_nak_ok_o,
    output logic                      unhandled_unexp_nak_o,
    input  logic                      host_idle_i,
    input  logic                      event_nak_i,
    input  logic                      event_stretch_timeout_i,
    input  logic                      rx_fifo_wvalid_i,
    input  logic [7:0]                rx_fifo_wdata_i
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RCMD  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] FLUSH = 3'd5;

    logic [2:0] state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic       rnw_q, rnw_d;
    logic [7:0] len_q, len_d, rem_q, rem_d;
    logic       busy_seen_q, busy_seen_d;
    logic       data_acc_q, data_acc_d;
    logic [1:0] status_q, status_d;
    logic       rdata_valid_q;
    logic [7:0] rdata_q;
    logic       fmt_hs, abort, rx_take;

    assign fmt_hs = fmt_fifo_rvalid_o && fmt_fifo_rready_i;
    assign abort  = state_q != IDLE && state_q != FLUSH && (event_nak_i || event_stretch_timeout_i);
    assign rx_take = rx_fifo_wvalid_i && state_q != IDLE && rnw_q;

    assign fmt_fifo_depth_o         = FifoDepthWidth'(fmt_fifo_rvalid_o);
    assign fmt_flag_read_continue_o = 1'b0;
    assign fmt_flag_nak_ok_o        = 1'b0;
    assign unhandled_unexp_nak_o    = state_q == FLUSH;
    assign rdata_valid_o            = rdata_valid_q;
    assign rdata_o                  = rdata_q;

    always_comb begin
        // ready is masked by reset so every output reads 0 while rst_ni is low
        req_ready_o             = rst_ni && state_q == IDLE && host_idle_i;
        fmt_fifo_rvalid_o       = state_q == ADDR || state_q == RCMD || (state_q == WDATA && wdata_valid_i);
        fmt_byte_o              = state_q == ADDR  ? {addr_q, rnw_q} :
                                  state_q == WDATA ? wdata_i :
                                  state_q == RCMD  ? len_q : 8'h00;
        fmt_flag_start_before_o = state_q == ADDR;
        fmt_flag_stop_after_o   = (state_q == ADDR && len_q == 8'd0) || (state_q == WDATA && rem_q == 8'd1) ||
                                  state_q == RCMD;
        fmt_flag_read_bytes_o   = state_q == RCMD;
        wdata_ready_o           = (state_q == WDATA && fmt_fifo_rready_i) || (state_q == FLUSH && !rnw_q);
        done_o                  = (state_q == WAIT && host_idle_i && busy_seen_q && !abort) ||
                                  (state_q == FLUSH && host_idle_i && (rnw_q || rem_q == 8'd0));
        status_o                = (state_q == FLUSH && done_o) ? status_q : 2'd0;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        len_d       = len_q;
        rem_d       = rem_q;
        // busy is tracked from ADDR onward so a PHY that goes busy early is not missed
        busy_seen_d = busy_seen_q || (state_q != IDLE && !host_idle_i);
        data_acc_d  = data_acc_q;
        status_d    = status_q;
        case (state_q)
            IDLE: if (req_valid_i && req_ready_o) begin
                addr_d      = req_addr_i;
                rnw_d       = req_rnw_i;
                len_d       = req_len_i;
                rem_d       = req_len_i;
                busy_seen_d = 1'b0;
                data_acc_d  = 1'b0;
                status_d    = 2'd0;
                state_d     = ADDR;
            end
            ADDR: if (fmt_hs) state_d = len_q == 8'd0 ? WAIT : rnw_q ? RCMD : WDATA;
            WDATA: if (fmt_hs) begin
                rem_d      = rem_q - 8'd1;
                data_acc_d = 1'b1;
                if (rem_q == 8'd1) state_d = WAIT;
            end
            RCMD: if (fmt_hs) begin
                data_acc_d = 1'b1;
                state_d    = WAIT;
            end
            WAIT: if (done_o) state_d = IDLE;
            FLUSH: begin
                if (!rnw_q && wdata_valid_i && rem_q != 8'd0) rem_d = rem_q - 8'd1;
                if (done_o) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a same-cycle fmt handshake has already updated the counters above; only the target changes
        if (abort) begin
            state_d  = FLUSH;
            status_d = event_stretch_timeout_i ? 2'd3 : (state_q == ADDR || !data_acc_q) ? 2'd1 : 2'd2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rnw_q         <= 1'b0;
            len_q         <= '0;
            rem_q         <= '0;
            busy_seen_q   <= 1'b0;
            data_acc_q    <= 1'b0;
            status_q      <= '0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rnw_q         <= rnw_d;
            len_q         <= len_d;
            rem_q         <= rem_d;
            busy_seen_q   <= busy_seen_d;
            data_acc_q    <= data_acc_d;
            status_q      <= status_d;
            rdata_valid_q <= rx_take;
            if (rx_take) rdata_q <= rx_fifo_wdata_i;
        end
    end
endmodule

// File: tb/tb_i2c_host_txn_sequencer.sv
// tb_i2c_host_txn_sequencer: randomized scoreboard bench for i2c_host_txn_sequencer
module tb_i2c_host_txn_sequencer;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_ni;
    logic       req_valid_i, req_ready_o, req_rnw_i;
    logic [6:0] req_addr_i;
    logic [7:0] req_len_i;
    logic       wdata_valid_i, wdata_ready_o;
    logic [7:0] wdata_i;
    logic       rdata_valid_o;
    logic [7:0] rdata_o;
    logic       done_o;
    logic [1:0] status_o;
    logic       fmt_fifo_rvalid_o, fmt_fifo_rready_i;
    logic [6:0] fmt_fifo_depth_o;
    logic [7:0] fmt_byte_o;
    logic       fmt_flag_start_before_o, fmt_flag_stop_after_o, fmt_flag_read_bytes_o;
    logic       fmt_flag_read_continue_o, fmt_flag_nak_ok_o, unhandled_unexp_nak_o;
    logic       host_idle_i, event_nak_i, event_stretch_timeout_i;
    logic       rx_fifo_wvalid_i;
    logic [7:0] rx_fifo_wdata_i;

    i2c_host_txn_sequencer #(.FifoDepth(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_rnw_i(req_rnw_i), .req_len_i(req_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o), .status_o(status_o),
        .fmt_fifo_rvalid_o(fmt_fifo_rvalid_o), .fmt_fifo_depth_o(fmt_fifo_depth_o),
        .fmt_fifo_rready_i(fmt_fifo_rready_i), .fmt_byte_o(fmt_byte_o),
        .fmt_flag_start_before_o(fmt_flag_start_before_o), .fmt_flag_stop_after_o(fmt_flag_stop_after_o),
        .fmt_flag_read_bytes_o(fmt_flag_read_bytes_o), .fmt_flag_read_continue_o(fmt_flag_read_continue_o),
        .fmt_flag_nak_ok_o(fmt_flag_nak_ok_o), .unhandled_unexp_nak_o(unhandled_unexp_nak_o),
        .host_idle_i(host_idle_i), .event_nak_i(event_nak_i),
        .event_stretch_timeout_i(event_stretch_timeout_i),
        .rx_fifo_wvalid_i(rx_fifo_wvalid_i), .rx_fifo_wdata_i(rx_fifo_wdata_i)
    );

    // entry layout: {byte, start_before, stop_after, read_bytes, read_continue, nak_ok}
    logic [12:0] exp_fmt[$];
    logic [7:0]  exp_rd[$];
    logic [1:0]  exp_st[$];
    logic [7:0]  wq[$], rq[$];
    logic [12:0] mon_f;
    logic [7:0]  mon_r;
    logic [1:0]  mon_s;
    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {28'd0, req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o, status_o,
                fmt_fifo_rvalid_o, fmt_fifo_depth_o, fmt_byte_o, fmt_flag_start_before_o,
                fmt_flag_stop_after_o, fmt_flag_read_bytes_o, fmt_flag_read_continue_o,
                fmt_flag_nak_ok_o, unhandled_unexp_nak_o};
    endfunction

    always @(negedge clk_i) if (rst_ni) begin
        if (fmt_fifo_rvalid_o && fmt_fifo_rready_i) begin
            check("fmt_pending", 64'(exp_fmt.size() != 0), 1);
            if (exp_fmt.size() != 0) begin
                mon_f = exp_fmt.pop_front();
                check("fmt_entry", {fmt_byte_o, fmt_flag_start_before_o, fmt_flag_stop_after_o,
                      fmt_flag_read_bytes_o, fmt_flag_read_continue_o, fmt_flag_nak_ok_o}, mon_f);
            end
            check("fmt_depth", fmt_fifo_depth_o, 1);
        end
        if (rdata_valid_o) begin
            check("rdata_pending", 64'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) begin
                mon_r = exp_rd.pop_front();
                check("rdata", rdata_o, mon_r);
            end
        end
        if (done_o) begin
            check("done_pending", 64'(exp_st.size() != 0), 1);
            if (exp_st.size() != 0) begin
                mon_s = exp_st.pop_front();
                check("status", status_o, mon_s);
                check("unexp_nak_at_done", unhandled_unexp_nak_o, mon_s != 2'd0);
            end
        end
    end

    task automatic quiet();
        req_valid_i = 0; wdata_valid_i = 0; fmt_fifo_rready_i = 0;
        event_nak_i = 0; event_stretch_timeout_i = 0; rx_fifo_wvalid_i = 0;
    endtask

    task automatic fill(input int n);
        wq.delete(); rq.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back(8'($urandom));
            rq.push_back(8'($urandom));
        end
    endtask

    // fk: bit0 NAK, bit1 stretch timeout; fp: fmt entries accepted before the event fires;
    // sc: event coincides with a presented entry that the PHY accepts; rst_at: reset after that many entries
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] n,
                           input int fk, input int fp, input bit sc, input int rst_at);
        int total = r ? (n == 0 ? 1 : 2) : int'(n) + 1;
        int nexp;
        int acc = 0, ws = 0, rxs = 0, cyc = 0, cd = 0;
        bit started = 0, fired = 0, over = 0, busy_on = 0, dn = 0, hsr, hsf, hsw;
        logic [12:0] ents[$];
        nexp = rst_at > 0 ? rst_at : fk == 0 ? total : (sc && fp < total) ? fp + 1 : fp;
        ents.push_back({a, r, 1'b1, n == 8'd0, 3'b000});
        if (r && n != 0) ents.push_back({n, 1'b0, 1'b1, 1'b1, 2'b00});
        if (!r) for (int i = 0; i < int'(n); i++) ents.push_back({wq[i], 1'b0, i == int'(n) - 1, 3'b000});
        for (int i = 0; i < nexp; i++) exp_fmt.push_back(ents[i]);
        if (rst_at == 0) exp_st.push_back(fk == 0 ? 2'd0 : fk[1] ? 2'd3 : fp <= 1 ? 2'd1 : 2'd2);
        if (r && fk == 0 && rst_at == 0) for (int i = 0; i < int'(n); i++) exp_rd.push_back(rq[i]);
        req_valid_i = 1; req_addr_i = a; req_rnw_i = r; req_len_i = n;
        while (1) begin
            @(negedge clk_i);
            hsr = req_valid_i && req_ready_o;
            hsf = fmt_fifo_rvalid_o && fmt_fifo_rready_i;
            hsw = wdata_valid_i && wdata_ready_o;
            dn = done_o;
            @(posedge clk_i); #1;
            if (hsr) begin started = 1; req_valid_i = 0; end
            if (hsf) acc++;
            if (hsw) ws++;
            event_nak_i = 0; event_stretch_timeout_i = 0; rx_fifo_wvalid_i = 0;
            if (dn || ++cyc > 3000) break;
            if (rst_at > 0 && acc == rst_at) begin
                fmt_fifo_rready_i = 1; wdata_valid_i = 1; wdata_i = wq[ws]; host_idle_i = 1;
                #2 rst_ni = 0;
                #1 check("async_reset_outputs", outs(), 0);
                quiet(); host_idle_i = 0;
                repeat (2) @(posedge clk_i);
                #1 rst_ni = 1;
                #1 check("ready_after_reset_busy", req_ready_o, 0);
                host_idle_i = 1;
                #1 check("ready_after_reset_idle", req_ready_o, 1);
                return;
            end
            if (started && acc >= 1 && !busy_on) begin busy_on = 1; host_idle_i = 0; end
            if (!over && (fk != 0 ? fired : (acc == total && rxs == (r ? int'(n) : 0)))) begin
                over = 1; cd = $urandom_range(1, 4);
            end else if (over && cd > 0) begin
                cd--;
                if (cd == 0) host_idle_i = 1;
            end
            if (started && fk != 0 && !fired && acc == fp) begin
                fired = 1; event_nak_i = fk[0]; event_stretch_timeout_i = fk[1];
                fmt_fifo_rready_i = sc;
                wdata_valid_i = sc && !r && ws < int'(n);
                wdata_i = ws < int'(n) ? wq[ws] : 8'h00;
            end else begin
                fmt_fifo_rready_i = $urandom_range(0, 3) != 0;
                wdata_valid_i = !r && ws < int'(n) && $urandom_range(0, 2) != 0;
                wdata_i = wdata_valid_i ? wq[ws] : 8'($urandom);
            end
            if (r && fk == 0 && acc == total && rxs < int'(n) && $urandom_range(0, 1) == 1) begin
                rx_fifo_wvalid_i = 1; rx_fifo_wdata_i = rq[rxs]; rxs++;
            end else if (!r && $urandom_range(0, 7) == 0) begin
                rx_fifo_wvalid_i = 1; rx_fifo_wdata_i = 8'($urandom);
            end
        end
        quiet(); host_idle_i = 1;
        check("done_within_budget", dn, 1);
        if (!r) check("wdata_all_consumed", ws, n);
        if (!dn) begin
            rst_ni = 0; #2 rst_ni = 1;
            exp_fmt.delete(); exp_rd.delete(); exp_st.delete();
        end
    endtask

    task automatic idle_strays();
        for (int i = 0; i < 2; i++) begin
            rx_fifo_wvalid_i = 1; rx_fifo_wdata_i = 8'($urandom);
            @(posedge clk_i); #1;
        end
        rx_fifo_wvalid_i = 0;
        @(posedge clk_i); #1;
        check("queues_drained", exp_fmt.size() + exp_rd.size() + exp_st.size(), 0);
    endtask

    initial begin
        quiet(); req_addr_i = 0; req_rnw_i = 0; req_len_i = 0; wdata_i = 0; rx_fifo_wdata_i = 0;
        host_idle_i = 1; rst_ni = 0;
        #12 check("reset_outputs", outs(), 0);
        @(posedge clk_i); #1 rst_ni = 1;
        wq = '{8'hA1, 8'hA2, 8'hA3};
        run_txn(7'h50, 0, 3, 0, 0, 0, 0); idle_strays();
        rq = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_txn(7'h50, 1, 4, 0, 0, 0, 0); idle_strays();
        run_txn(7'h50, 1'b0, 0, 1, 1, 0, 0); idle_strays();
        fill(5); run_txn(7'h50, 0, 5, 1, 3, 0, 0); idle_strays();
        fill(4); run_txn(7'h2C, 1, 4, 3, 2, 0, 0); idle_strays();
        fill(3); run_txn(7'h50, 0, 3, 0, 0, 0, 2); idle_strays();
        fill(255); run_txn(7'h13, 1, 255, 0, 0, 0, 0); idle_strays();
        for (int t = 0; t < 60; t++) begin
            logic       r;
            logic [7:0] n;
            int fk, tot;
            r = 1'($urandom);
            n = $urandom_range(0, 9) == 0 ? 8'($urandom) : 8'($urandom_range(0, 8));
            fk = $urandom_range(0, 1) == 1 ? 0 : $urandom_range(1, 3);
            tot = r ? (n == 0 ? 1 : 2) : int'(n) + 1;
            fill(n);
            run_txn(7'($urandom), r, n, fk, $urandom_range(0, tot), 1'($urandom), 0);
            idle_strays();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
